// File: rtl/sad_pkg.sv
// Shared definitions for the SAD block sequencer and its min-tracker.
//   sad_state_e  : sequencer FSM states
//   PIX_W        : pixel width (bits)
//   ROW_W        : one memory row = 8 pixels
//   CLEAR_CYCLES : cycles the accumulator clear is held
//   SAD_W        : width of SAD totals
package sad_pkg;
   localparam int PIX_W        = 8;
   localparam int ROW_W        = 8 * PIX_W;
   localparam int CLEAR_CYCLES = 2;
   localparam int SAD_W        = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } sad_state_e;
endpackage

// File: rtl/sad_min_tracker.sv
// Tracks the smallest block SAD seen and the index of the candidate that
// produced it. The candidate counter advances once per completed block.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   min_clr_i    : restart tracking (best = all-ones, index/counter = 0)
//   done_i       : one-cycle pulse, block_sad_i is valid on it
//   block_sad_i  : SAD of the block just finished
//   best_sad_o   : smallest SAD so far (first minimum kept on ties)
//   best_idx_o   : candidate index of best_sad_o
module sad_min_tracker
   import sad_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             min_clr_i,
   input  logic             done_i,
   input  logic [SAD_W-1:0] block_sad_i,
   output logic [SAD_W-1:0] best_sad_o,
   output logic [7:0]       best_idx_o
);

   logic [SAD_W-1:0] best_sad_q, best_sad_d;
   logic [7:0]       best_idx_q, best_idx_d;
   logic [7:0]       cand_q, cand_d;

   always_comb begin
      best_sad_d = best_sad_q;
      best_idx_d = best_idx_q;
      cand_d     = cand_q;
      if (done_i) begin
         cand_d = cand_q + 8'd1;
         // Strict compare keeps the earliest candidate on equal SADs.
         if (block_sad_i < best_sad_q) begin
            best_sad_d = block_sad_i;
            best_idx_d = cand_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || min_clr_i) begin
         best_sad_q <= '1;
         best_idx_q <= '0;
         cand_q     <= '0;
      end else begin
         best_sad_q <= best_sad_d;
         best_idx_q <= best_idx_d;
         cand_q     <= cand_d;
      end
   end

   assign best_sad_o = best_sad_q;
   assign best_idx_o = best_idx_q;

endmodule

// File: rtl/sad_block_sequencer.sv
// Sequences one SAD block: clears the external accumulator, reads ROWS rows
// from the original and reference pixel memories, presents the pixel pairs
// to the accumulator, waits for the accumulator latency and captures the
// total into block_sad.
// Parameters: ROWS (rows per block, 1..16), AW (address width),
//             ACC_LAT (accumulator latency in cycles).
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   start                        : block request, sampled in IDLE only
//   org_base, ref_base, stride   : block base addresses and row stride
//   org/ref_rd_en, _rd_addr      : memory read requests
//   org/ref_rd_data              : row data, valid one cycle after rd_en
//   pix_org, pix_ref, pix_valid  : pixel pairs to the accumulator (zero when idle)
//   sad_clear                    : accumulator clear
//   sad_sum                      : running accumulator total
//   busy, done, block_sad        : status, one-cycle completion pulse, result
// Optional feature macro SAD_SEQ_MIN_TRACK_EN adds min_clr, best_sad, best_idx
// via the sad_min_tracker sub-module.
module sad_block_sequencer
   import sad_pkg::*;
#(
   parameter int ROWS    = 8,
   parameter int AW      = 12,
   parameter int ACC_LAT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AW-1:0]    org_base,
   input  logic [AW-1:0]    ref_base,
   input  logic [AW-1:0]    stride,
   output logic             org_rd_en,
   output logic             ref_rd_en,
   output logic [AW-1:0]    org_rd_addr,
   output logic [AW-1:0]    ref_rd_addr,
   input  logic [ROW_W-1:0] org_rd_data,
   input  logic [ROW_W-1:0] ref_rd_data,
   output logic [ROW_W-1:0] pix_org,
   output logic [ROW_W-1:0] pix_ref,
   output logic             pix_valid,
   output logic             sad_clear,
   input  logic [SAD_W-1:0] sad_sum,
   output logic             busy,
   output logic             done,
   output logic [SAD_W-1:0] block_sad
`ifdef SAD_SEQ_MIN_TRACK_EN
   ,
   input  logic             min_clr,
   output logic [SAD_W-1:0] best_sad,
   output logic [7:0]       best_idx
`endif
);

   // One shared phase counter serves CLEAR, FEED and DRAIN.
   localparam int CNT_MAX_A = (ROWS > ACC_LAT + 1) ? ROWS : ACC_LAT + 1;
   localparam int CNT_MAX   = (CNT_MAX_A > CLEAR_CYCLES) ? CNT_MAX_A : CLEAR_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   sad_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    org_addr_q, org_addr_d;
   logic [AW-1:0]    ref_addr_q, ref_addr_d;
   logic [AW-1:0]    stride_q, stride_d;
   logic             pix_valid_q;
   logic [SAD_W-1:0] block_sad_q, block_sad_d;
   logic             rd_en;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      org_addr_d  = org_addr_q;
      ref_addr_d  = ref_addr_q;
      stride_d    = stride_q;
      block_sad_d = block_sad_q;
      rd_en       = 1'b0;
      sad_clear   = 1'b0;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CLEAR;
               cnt_d      = '0;
               org_addr_d = org_base;
               ref_addr_d = ref_base;
               stride_d   = stride;
            end
         end
         CLEAR: begin
            sad_clear = 1'b1;
            if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
               state_d = FEED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FEED: begin
            rd_en      = 1'b1;
            // Address registers walk the rows; wrap modulo 2^AW is natural.
            org_addr_d = org_addr_q + stride_q;
            ref_addr_d = ref_addr_q + stride_q;
            if (cnt_q == CNT_W'(ROWS - 1)) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            // The first DRAIN cycle still presents the last pixel row, so the
            // state spans ACC_LAT+1 cycles; the sum is complete on the last.
            if (cnt_q == CNT_W'(ACC_LAT)) begin
               block_sad_d = sad_sum;
               state_d     = DONE;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pix_valid_q <= 1'b0;
         block_sad_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pix_valid_q <= rd_en;
         block_sad_q <= block_sad_d;
      end
   end

   // Address/stride registers are only observed while FEED drives rd_en.
   always_ff @(posedge clk) begin
      org_addr_q <= org_addr_d;
      ref_addr_q <= ref_addr_d;
      stride_q   <= stride_d;
   end

   assign org_rd_en   = rd_en;
   assign ref_rd_en   = rd_en;
   assign org_rd_addr = rd_en ? org_addr_q : '0;
   assign ref_rd_addr = rd_en ? ref_addr_q : '0;

   // Memory data arrives one cycle after the read; gate it so the
   // free-running accumulator adds zero outside the valid window.
   assign pix_valid = pix_valid_q;
   assign pix_org   = pix_valid_q ? org_rd_data : '0;
   assign pix_ref   = pix_valid_q ? ref_rd_data : '0;

   assign busy      = (state_q != IDLE);
   assign block_sad = block_sad_q;

`ifdef SAD_SEQ_MIN_TRACK_EN
   sad_min_tracker u_min_tracker (
      .clk         (clk),
      .reset       (reset),
      .min_clr_i   (min_clr),
      .done_i      (done),
      .block_sad_i (block_sad_q),
      .best_sad_o  (best_sad),
      .best_idx_o  (best_idx)
   );
`endif

endmodule

// File: tb/tb_sad_block_sequencer.sv
// Bench for sad_block_sequencer: pixel memories with one-cycle read latency,
// a two-stage SAD accumulator, a schedule-based reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_sad_block_sequencer;
   localparam int ROWS    = 8;
   localparam int AW      = 12;
   localparam int ACC_LAT = 2;
   localparam int DONE_PH = ROWS + 4 + ACC_LAT;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [AW-1:0] org_base, ref_base, stride;
   logic          org_rd_en, ref_rd_en;
   logic [AW-1:0] org_rd_addr, ref_rd_addr;
   logic [63:0]   org_rd_data = '0, ref_rd_data = '0;
   logic [63:0]   pix_org, pix_ref;
   logic          pix_valid, sad_clear, busy, done;
   logic [15:0]   sad_sum, block_sad;
`ifdef SAD_SEQ_MIN_TRACK_EN
   logic          min_clr;
   logic [15:0]   best_sad;
   logic [7:0]    best_idx;
`endif

   always #5 clk = ~clk;

   sad_block_sequencer #(.ROWS(ROWS), .AW(AW), .ACC_LAT(ACC_LAT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .org_base(org_base), .ref_base(ref_base), .stride(stride),
      .org_rd_en(org_rd_en), .ref_rd_en(ref_rd_en),
      .org_rd_addr(org_rd_addr), .ref_rd_addr(ref_rd_addr),
      .org_rd_data(org_rd_data), .ref_rd_data(ref_rd_data),
      .pix_org(pix_org), .pix_ref(pix_ref), .pix_valid(pix_valid),
      .sad_clear(sad_clear), .sad_sum(sad_sum),
      .busy(busy), .done(done), .block_sad(block_sad)
`ifdef SAD_SEQ_MIN_TRACK_EN
      , .min_clr(min_clr), .best_sad(best_sad), .best_idx(best_idx)
`endif
   );

   // Pixel memories: garbage on the data bus when not read.
   logic [63:0] org_mem [0:4095];
   logic [63:0] ref_mem [0:4095];
   always @(posedge clk) begin
      org_rd_data <= org_rd_en ? org_mem[org_rd_addr] : 64'hA5A5_5A5A_DEAD_BEEF;
      ref_rd_data <= ref_rd_en ? ref_mem[ref_rd_addr] : 64'h0123_4567_89AB_CDEF;
   end

   function automatic logic [15:0] row_sad(input logic [63:0] a, input logic [63:0] b);
      logic [15:0] s = '0;
      for (int k = 0; k < 8; k++) begin
         if (a[8*k +: 8] > b[8*k +: 8]) s += 16'(a[8*k +: 8] - b[8*k +: 8]);
         else                          s += 16'(b[8*k +: 8] - a[8*k +: 8]);
      end
      return s;
   endfunction

   // Accumulator with ACC_LAT = 2: per-row sum stage, then running total.
   logic [15:0] acc_row = '0, acc_tot = '0;
   always @(posedge clk) begin
      if (sad_clear) begin
         acc_row <= '0;
         acc_tot <= '0;
      end else begin
         acc_row <= row_sad(pix_org, pix_ref);
         acc_tot <= acc_tot + acc_row;
      end
   end
   assign sad_sum = acc_tot;

   function automatic logic [15:0] block_sad_exp(input logic [AW-1:0] ob, input logic [AW-1:0] rb,
                                                 input logic [AW-1:0] st);
      logic [15:0]   s = '0;
      logic [AW-1:0] oa, ra;
      for (int r = 0; r < ROWS; r++) begin
         oa = ob + AW'(r) * st;
         ra = rb + AW'(r) * st;
         s += row_sad(org_mem[oa], ref_mem[ra]);
      end
      return s;
   endfunction

   // Reference model: phase within the block since the accepting edge.
   int            cyc = 0;
   bit            m_act = 1'b0;
   int            m_ph = 0;
   int            s_cyc = 0;
   logic [AW-1:0] m_ob = '0, m_rb = '0, m_st = '0;
   logic [15:0]   m_sad = '0, exp_bsad = '0;
   logic [15:0]   m_best = 16'hFFFF;
   logic [7:0]    m_bidx = '0, m_cnt = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_act    <= 1'b0;
         m_ph     <= 0;
         exp_bsad <= '0;
      end else if (m_act) begin
         if (m_ph == DONE_PH) begin
            m_act <= 1'b0;
            m_ph  <= 0;
         end else begin
            m_ph <= m_ph + 1;
            if (m_ph + 1 == DONE_PH) exp_bsad <= m_sad;
         end
      end else if (start) begin
         m_act <= 1'b1;
         m_ph  <= 1;
         s_cyc <= cyc;
         m_ob  <= org_base;
         m_rb  <= ref_base;
         m_st  <= stride;
         m_sad <= block_sad_exp(org_base, ref_base, stride);
      end
`ifdef SAD_SEQ_MIN_TRACK_EN
      if (reset || min_clr) begin
         m_best <= 16'hFFFF;
         m_bidx <= '0;
         m_cnt  <= '0;
      end else if (m_act && m_ph == DONE_PH) begin
         m_cnt <= m_cnt + 8'd1;
         if (exp_bsad < m_best) begin
            m_best <= exp_bsad;
            m_bidx <= m_cnt;
         end
      end
`endif
   end

   int pass_cnt = 0;
   int chk_cnt  = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Per-cycle comparison against the model.
   logic          e_clr, e_rd, e_pv, e_done, e_busy;
   logic [AW-1:0] e_oa, e_ra, pa_o, pa_r;
   logic [63:0]   e_po, e_pr;
   always @(negedge clk) begin
      if (chk_en) begin
         e_busy = m_act;
         e_clr  = m_act && m_ph >= 1 && m_ph <= 2;
         e_rd   = m_act && m_ph >= 3 && m_ph <= ROWS + 2;
         e_pv   = m_act && m_ph >= 4 && m_ph <= ROWS + 3;
         e_done = m_act && m_ph == DONE_PH;
         e_oa   = e_rd ? m_ob + AW'(m_ph - 3) * m_st : '0;
         e_ra   = e_rd ? m_rb + AW'(m_ph - 3) * m_st : '0;
         pa_o   = m_ob + AW'(m_ph - 4) * m_st;
         pa_r   = m_rb + AW'(m_ph - 4) * m_st;
         e_po   = e_pv ? org_mem[pa_o] : '0;
         e_pr   = e_pv ? ref_mem[pa_r] : '0;
         check("ctrl", {busy, sad_clear, org_rd_en, ref_rd_en, pix_valid, done},
                       {e_busy, e_clr, e_rd, e_rd, e_pv, e_done});
         check("addr", {org_rd_addr, ref_rd_addr}, {e_oa, e_ra});
         check("pix", {pix_org, pix_ref}, {e_po, e_pr});
         check("block_sad", block_sad, exp_bsad);
`ifdef SAD_SEQ_MIN_TRACK_EN
         check("best", {best_sad, best_idx}, {m_best, m_bidx});
`endif
      end
   end

   logic [AW-1:0] oq[$], rq[$];
   always @(negedge clk) begin
      if (org_rd_en) begin
         oq.push_back(org_rd_addr);
         rq.push_back(ref_rd_addr);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input string nm, output int dc);
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         step(1);
         n++;
      end
      check({nm, "_done_seen"}, done, 1'b1);
      dc = cyc;
      step(1);
   endtask

   task automatic fill_const(input logic [7:0] o, input logic [7:0] r);
      for (int a = 0; a < 4096; a++) begin
         org_mem[a] = {8{o}};
         ref_mem[a] = {8{r}};
      end
   endtask

   task automatic fill_pattern();
      for (int a = 0; a < 4096; a++)
         for (int k = 0; k < 8; k++) begin
            org_mem[a][8*k +: 8] = 8'((a * 7 + k * 31) & 255);
            ref_mem[a][8*k +: 8] = 8'((a * 13 + k * 17 + 90) & 255);
         end
   endtask

   task automatic run_block(input string nm, input logic [AW-1:0] ob, input logic [AW-1:0] rb,
                            input logic [AW-1:0] st);
      int s, dc;
      org_base = ob; ref_base = rb; stride = st;
      start = 1'b1;
      s = cyc;
      step(1);
      start = 1'b0;
      wait_done(nm, dc);
      check({nm, "_latency"}, dc - s, DONE_PH);
   endtask

   logic [AW-1:0] exp_a_org [8] = '{12'h010, 12'h050, 12'h090, 12'h0D0, 12'h110, 12'h150, 12'h190, 12'h1D0};
   logic [AW-1:0] exp_a_ref [8] = '{12'h200, 12'h240, 12'h280, 12'h2C0, 12'h300, 12'h340, 12'h380, 12'h3C0};
   logic [AW-1:0] exp_w_org [8] = '{12'hFC0, 12'hFE0, 12'h000, 12'h020, 12'h040, 12'h060, 12'h080, 12'h0A0};

   initial begin
      int s, dc, prev, nd;
      reset = 1'b1; start = 1'b0;
      org_base = '0; ref_base = '0; stride = '0;
`ifdef SAD_SEQ_MIN_TRACK_EN
      min_clr = 1'b0;
`endif
      fill_const(8'd200, 8'd100);
      step(1);
      chk_en = 1'b1;
      step(2);
      check("rst_ctrl", {busy, done, sad_clear, org_rd_en, ref_rd_en, pix_valid}, 6'b0);
      check("rst_addr", {org_rd_addr, ref_rd_addr}, '0);
      check("rst_pix", {pix_org, pix_ref}, '0);
      check("rst_block_sad", block_sad, 16'd0);
      reset = 1'b0;
      step(1);

      // Uniform 200/100 block with the base/stride address pattern.
      oq.delete(); rq.delete();
      run_block("A", 12'h010, 12'h200, 12'h040);
      check("A_block_sad", block_sad, 16'd6400);
      check("A_nreads", oq.size(), ROWS);
      for (int i = 0; i < ROWS; i++) begin
         check($sformatf("A_org_addr%0d", i), oq[i], exp_a_org[i]);
         check($sformatf("A_ref_addr%0d", i), rq[i], exp_a_ref[i]);
      end
      step(3);
      check("A_block_sad_hold", block_sad, 16'd6400);

      // Varied pixel data, wrapping addresses.
      fill_pattern();
      oq.delete(); rq.delete();
      run_block("W", 12'hFC0, 12'h123, 12'h020);
      check("W_nreads", oq.size(), ROWS);
      for (int i = 0; i < ROWS; i++)
         check($sformatf("W_org_addr%0d", i), oq[i], exp_w_org[i]);
      step(2);

      // Reset during block cycle 7, then a fresh block.
      org_base = 12'h300; ref_base = 12'h700; stride = 12'h011;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(6);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("R_ctrl", {busy, done, sad_clear, org_rd_en, ref_rd_en, pix_valid}, 6'b0);
      check("R_addr", {org_rd_addr, ref_rd_addr}, '0);
      check("R_pix", {pix_org, pix_ref}, '0);
      check("R_block_sad", block_sad, 16'd0);
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) nd++;
         step(1);
      end
      check("R_no_done", nd, 0);
      run_block("R2", 12'h300, 12'h700, 12'h011);
      step(2);

      // start held high: back-to-back blocks every 15 cycles.
      fill_const(8'd200, 8'd100);
      org_base = 12'h000; ref_base = 12'h800; stride = 12'h008;
      start = 1'b1;
      s = cyc;
      prev = s;
      for (int b = 0; b < 4; b++) begin
         wait_done($sformatf("B%0d", b), dc);
         check($sformatf("B%0d_spacing", b), dc - prev, (b == 0) ? DONE_PH : DONE_PH + 1);
         check($sformatf("B%0d_block_sad", b), block_sad, 16'd6400);
         prev = dc;
      end
      start = 1'b0;
      step(3);

`ifdef SAD_SEQ_MIN_TRACK_EN
      // Minimum tracking over SADs 500, 300, 300, 700.
      fill_const(8'd0, 8'd0);
      org_mem[12'h800] = {48'h0, 8'd250, 8'd250};
      org_mem[12'h900] = {48'h0, 8'd150, 8'd150};
      org_mem[12'hA00] = {48'h0, 8'd150, 8'd150};
      org_mem[12'hB00] = {40'h0, 8'd200, 8'd250, 8'd250};
      min_clr = 1'b1;
      step(1);
      min_clr = 1'b0;
      run_block("M0", 12'h800, 12'hC00, 12'h001);
      check("M0_block_sad", block_sad, 16'd500);
      run_block("M1", 12'h900, 12'hC00, 12'h001);
      run_block("M2", 12'hA00, 12'hC00, 12'h001);
      run_block("M3", 12'hB00, 12'hC00, 12'h001);
      check("M3_block_sad", block_sad, 16'd700);
      check("M_best", {best_sad, best_idx}, {16'd300, 8'd1});
      min_clr = 1'b1;
      step(1);
      min_clr = 1'b0;
      check("M_clr", {best_sad, best_idx}, {16'hFFFF, 8'd0});
      step(2);
`endif

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/sad_block_sequencer.md
SAD_BLOCK_SEQUENCER -- requirements
Module: sad_block_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning pixel rows per block (legal 1..16).
REQ-002 SHALL have parameter AW, default 12, meaning pixel-memory address width.
REQ-003 SHALL have parameter ACC_LAT, default 2, meaning cycles from pixel presentation to inclusion in sad_sum.
REQ-004 SHALL have port clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle block request, sampled in IDLE only.
REQ-007 SHALL have ports org_base, ref_base, stride  in  AW each  block base addresses and row stride.
REQ-008 SHALL have ports org_rd_en, ref_rd_en  out  1 and org_rd_addr, ref_rd_addr  out  AW  memory read requests.
REQ-009 SHALL have ports org_rd_data, ref_rd_data  in  64  row data (8 x 8-bit pixels, pixel k at [8k+7:8k]), valid exactly 1 cycle after rd_en.
REQ-010 SHALL have ports pix_org, pix_ref  out  64 and pix_valid  out  1  pixel pairs driven to the SAD accumulator.
REQ-011 SHALL have port sad_clear  out  1  accumulator clear, connected to the accumulator reset.
REQ-012 SHALL have port sad_sum  in  16  running accumulator total.
REQ-013 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), block_sad  out  16.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-015 IDLE->CLEAR on start; base addresses and stride SHALL be latched on that edge; start outside IDLE SHALL be ignored.
REQ-016 CLEAR SHALL last exactly 2 cycles with sad_clear=1; sad_clear SHALL be 0 in all other states.
REQ-017 FEED SHALL last ROWS cycles, asserting org_rd_en and ref_rd_en each cycle with addr = base + row*stride, row 0..ROWS-1, modulo 2^AW.
REQ-018 Read data SHALL be registered onto pix_org/pix_ref with pix_valid=1 one cycle after each read, giving ROWS consecutive valid cycles.
REQ-019 When pix_valid=0, pix_org and pix_ref SHALL be all-zero so the free-running accumulator adds 0.
REQ-020 DRAIN SHALL start the cycle after the last pix_valid and last ACC_LAT cycles; sad_sum SHALL be captured into block_sad on the final DRAIN edge.
REQ-021 DONE SHALL last 1 cycle with done=1, then return to IDLE; block_sad SHALL hold until the next capture.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 With ROWS=8, ACC_LAT=2: start sampled at cycle 0 -> sad_clear cycles 1-2, reads cycles 3-10, pix_valid cycles 4-11, done at cycle 14.
REQ-024 A start in the same cycle as done SHALL be ignored; start on the cycle after done SHALL be accepted.

Reset
REQ-025 Reset SHALL force IDLE from any state, abandoning any in-flight block without a done pulse.
REQ-026 Reset values SHALL be: rd_en 0, rd_addr 0, pix_* 0, pix_valid 0, sad_clear 0, busy 0, done 0, block_sad 0.

Configuration
REQ-027 Macro SAD_SEQ_MIN_TRACK_EN SHALL, when defined, add outputs best_sad (16), best_idx (8) and input min_clr (1).
REQ-028 With SAD_SEQ_MIN_TRACK_EN: a candidate counter SHALL increment per done; best_sad/best_idx SHALL update when block_sad < best_sad (strict, first minimum kept); min_clr or reset SHALL set best_sad=16'hFFFF, best_idx=0, counter=0.
REQ-029 Without SAD_SEQ_MIN_TRACK_EN those ports and registers SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-030 FSM state enum, pixel width (8), row-data width (64) and CLEAR length (2) SHALL live in shared package sad_pkg.
REQ-031 The min-tracker SHALL be sub-module sad_min_tracker, instantiated only under SAD_SEQ_MIN_TRACK_EN; the rest SHALL be flat.

Verification
REQ-032 All org rows 8'd200, all ref rows 8'd100, with the existing 8-input SAD accumulator attached -> done at cycle 14, block_sad=6400.
REQ-033 org_base=12'h010, ref_base=12'h200, stride=12'h040 -> org addresses 0x010,0x050,...,0x1D0 and ref addresses 0x200,...,0x3C0.
REQ-034 org_base=12'hFC0, stride=12'h020 -> addresses wrap: 0xFC0,0xFE0,0x000,...,0x0A0.
REQ-035 Reset asserted at cycle 7 of a block -> next cycle IDLE, all outputs 0, no done; a fresh start yields correct block_sad.
REQ-036 start held high continuously -> back-to-back blocks, one done per 15 cycles, no overlapping reads.
REQ-037 With SAD_SEQ_MIN_TRACK_EN, block_sad sequence 500,300,300,700 -> best_sad=300, best_idx=1; min_clr -> 16'hFFFF, 0.
